// File: rtl/accumulator_alu_unit_pkg.sv
// Shared definitions for the accumulator ALU stage: opcodes, FSM state
// encoding and a small opcode classifier. The control unit uses the same package.
package accumulator_alu_unit_pkg;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_SLL  = 3'd5;
  localparam logic [2:0] OP_SRA  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // LOAD/ADD/SUB/AND/OR finish in the same edge that accepts them
  function automatic logic is_single_cycle(input logic [2:0] op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/accumulator_alu_unit_if.sv
// Bus between the control FSM (master) and the accumulator ALU stage (slave).
//
// Handshake: the master raises start together with a stable opcode/operand.
// The slave accepts it only on a rising clock edge where it is idle
// (busy==0); start is ignored, not queued, at any other time. busy is high
// from the cycle after acceptance until the slave is idle again, and done
// pulses for exactly one cycle when acc_out holds the final result.
interface accumulator_alu_unit_if #(parameter int WIDTH = 16);
  import accumulator_alu_unit_pkg::*;

  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_out;
  logic             busy;
  logic             done;
  logic             zero;
  logic             overflow;
  state_t           state;     // debug view of the FSM state

  modport master (
    output start, opcode, operand,
    input  acc_out, busy, done, zero, overflow, state
  );

  modport slave (
    input  start, opcode, operand,
    output acc_out, busy, done, zero, overflow, state
  );

endinterface

// File: rtl/accumulator_alu_unit_mul.sv
// Iterative shift-add multiplier (LSB-first). start latches the operands and
// clears the product; each step cycle adds the shifted multiplicand when the
// current multiplier bit is set. result is the product after the current step,
// so the caller can capture it on the cycle where last is high.
module accumulator_alu_unit_mul #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic [CNT_W-1:0] cnt;

  assign result = prod + (mplier[0] ? mcand : '0);
  assign last   = step && (cnt == CNT_W'(WIDTH - 1));

  // operand latch on start, one shift-add iteration per step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= multiplicand;
      mplier <= multiplier;
      prod   <= '0;
      cnt    <= '0;
    end else if (step) begin
      prod   <= result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/accumulator_alu_unit.sv
// Sequential ALU stage that updates the processor accumulator from the
// selected operand. Single-cycle ops retire at the accepting edge; shifts run
// one bit per cycle and multiply runs WIDTH shift-add cycles.
module accumulator_alu_unit
  import accumulator_alu_unit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  accumulator_alu_unit_if.slave bus
);

  state_t             state, state_next;
  logic [WIDTH-1:0]   acc;
  logic               zero_q;
  logic               ovf_q;
  logic [SHAMT_W-1:0] sh_cnt;
  logic               sh_sra;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH-1:0]   shift_res;
  logic [SHAMT_W-1:0] sh_amt;
  logic               accept;
  logic               mul_start;
  logic               mul_step;
  logic               mul_last;
  logic [WIDTH-1:0]   mul_res;

  assign accept    = (state == ST_IDLE) && bus.start;
  assign sh_amt    = bus.operand[SHAMT_W-1:0];
  assign mul_start = accept && (bus.opcode == OP_MUL);
  assign mul_step  = (state == ST_MUL);
  assign shift_res = sh_sra ? {acc[WIDTH-1], acc[WIDTH-1:1]} : {acc[WIDTH-2:0], 1'b0};

  assign bus.acc_out  = acc;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.state    = state;

  accumulator_alu_unit_mul #(.WIDTH(WIDTH), .CNT_W(SHAMT_W)) u_acc_shift_add_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .step         (mul_step),
    .multiplicand (bus.operand),
    .multiplier   (acc),
    .result       (mul_res),
    .last         (mul_last)
  );

  // single-cycle result and signed overflow for the current opcode
  always_comb begin
    alu_res = acc;
    alu_ovf = 1'b0;
    case (bus.opcode)
      OP_LOAD: alu_res = bus.operand;
      OP_ADD: begin
        alu_res = acc + bus.operand;
        alu_ovf = (acc[WIDTH-1] == bus.operand[WIDTH-1]) && (alu_res[WIDTH-1] != acc[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = acc - bus.operand;
        alu_ovf = (acc[WIDTH-1] != bus.operand[WIDTH-1]) && (alu_res[WIDTH-1] != acc[WIDTH-1]);
      end
      OP_AND:  alu_res = acc & bus.operand;
      OP_OR:   alu_res = acc | bus.operand;
      default: alu_res = acc;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_single_cycle(bus.opcode))                        state_next = ST_DONE;
          else if (bus.opcode == OP_MUL)                          state_next = ST_MUL;
          else if (sh_amt == '0)                                  state_next = ST_DONE;
          else                                                    state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: if (sh_cnt == SHAMT_W'(1)) state_next = ST_DONE;
      ST_MUL:   if (mul_last)              state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // accumulator, flags and shift counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      sh_cnt <= '0;
      sh_sra <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ovf_q <= alu_ovf;
            if (is_single_cycle(bus.opcode)) begin
              acc    <= alu_res;
              zero_q <= (alu_res == '0);
            end else if (bus.opcode != OP_MUL) begin
              sh_cnt <= sh_amt;
              sh_sra <= (bus.opcode == OP_SRA);
              if (sh_amt == '0) zero_q <= (acc == '0);
            end
          end
        end
        ST_SHIFT: begin
          acc    <= shift_res;
          sh_cnt <= sh_cnt - 1'b1;
          if (sh_cnt == SHAMT_W'(1)) zero_q <= (shift_res == '0);
        end
        ST_MUL: begin
          if (mul_last) begin
            acc    <= mul_res;
            zero_q <= (mul_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_alu_unit.sv
// Directed bench for accumulator_alu_unit with hand-computed expectations.
module tb_accumulator_alu_unit;
  import accumulator_alu_unit_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   bcnt;

  accumulator_alu_unit_if #(.WIDTH(16)) bus_if ();

  accumulator_alu_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // drive start for exactly one accepting edge; returns in cycle k+1
  task automatic issue(input logic [2:0] op, input logic [15:0] val);
    @(negedge clk);
    bus_if.start   = 1'b1;
    bus_if.opcode  = op;
    bus_if.operand = val;
    @(negedge clk);
    bus_if.start   = 1'b0;
  endtask

  // latency in cycles from the accepting edge to the done cycle, plus busy cycles seen
  task automatic wait_done(output int l, output int b);
    l = 1;
    b = 0;
    while (!bus_if.done && l < 100) begin
      if (bus_if.busy) b++;
      @(negedge clk);
      l++;
    end
    if (bus_if.busy) b++;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] val,
                        input int exp_lat, input logic [15:0] exp_acc);
    issue(op, val);
    wait_done(lat, bcnt);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_acc"}, bus_if.acc_out, exp_acc);
  endtask

  initial begin
    bus_if.start   = 1'b0;
    bus_if.opcode  = OP_LOAD;
    bus_if.operand = '0;
    rst = 1'b1;
    #2;
    chk("rst_acc",   bus_if.acc_out, 16'h0000);
    chk("rst_busy",  bus_if.busy, 1'b0);
    chk("rst_done",  bus_if.done, 1'b0);
    chk("rst_zero",  bus_if.zero, 1'b0);
    chk("rst_ovf",   bus_if.overflow, 1'b0);
    chk("rst_state", bus_if.state, ST_IDLE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // signed overflow on ADD
    run_op("load7fff", OP_LOAD, 16'h7FFF, 1, 16'h7FFF);
    run_op("add1", OP_ADD, 16'h0001, 1, 16'h8000);
    chk("add1_ovf",  bus_if.overflow, 1'b1);
    chk("add1_zero", bus_if.zero, 1'b0);

    // zero result, logic ops
    run_op("load5", OP_LOAD, 16'h0005, 1, 16'h0005);
    chk("load5_ovf", bus_if.overflow, 1'b0);
    run_op("sub5", OP_SUB, 16'h0005, 1, 16'h0000);
    chk("sub5_zero", bus_if.zero, 1'b1);
    chk("sub5_ovf",  bus_if.overflow, 1'b0);
    run_op("load0fff", OP_LOAD, 16'h0FFF, 1, 16'h0FFF);
    chk("load0fff_zero", bus_if.zero, 1'b0);
    run_op("and_f0", OP_AND, 16'h00F0, 1, 16'h00F0);
    run_op("or_f00", OP_OR, 16'h0F00, 1, 16'h0FF0);

    // SUB overflow, then cleared by LOAD
    run_op("load8000", OP_LOAD, 16'h8000, 1, 16'h8000);
    run_op("sub1", OP_SUB, 16'h0001, 1, 16'h7FFF);
    chk("sub1_ovf", bus_if.overflow, 1'b1);
    run_op("load8001", OP_LOAD, 16'h8001, 1, 16'h8001);
    chk("load8001_ovf", bus_if.overflow, 1'b0);

    // shifts
    run_op("sra3", OP_SRA, 16'h0003, 4, 16'hF000);
    chk("sra3_busy", bcnt, 4);
    @(negedge clk);
    chk("sra3_idle", bus_if.busy, 1'b0);
    run_op("sll0", OP_SLL, 16'h0010, 1, 16'hF000);
    run_op("load0123", OP_LOAD, 16'h0123, 1, 16'h0123);
    run_op("sll4", OP_SLL, 16'h0004, 5, 16'h1230);

    // multiply
    run_op("load0123b", OP_LOAD, 16'h0123, 1, 16'h0123);
    run_op("mul10", OP_MUL, 16'h0010, 17, 16'h1230);
    run_op("loadffff", OP_LOAD, 16'hFFFF, 1, 16'hFFFF);
    run_op("mulffff", OP_MUL, 16'hFFFF, 17, 16'h0001);
    chk("mulffff_zero", bus_if.zero, 1'b0);
    run_op("load7fffb", OP_LOAD, 16'h7FFF, 1, 16'h7FFF);
    run_op("add1b", OP_ADD, 16'h0001, 1, 16'h8000);
    run_op("mul2", OP_MUL, 16'h0002, 17, 16'h0000);
    chk("mul2_zero", bus_if.zero, 1'b1);
    chk("mul2_ovf",  bus_if.overflow, 1'b0);

    // start ignored mid-MUL and in the DONE cycle
    run_op("load3", OP_LOAD, 16'h0003, 1, 16'h0003);
    issue(OP_MUL, 16'h0005);
    repeat (4) @(negedge clk);
    bus_if.start   = 1'b1;
    bus_if.opcode  = OP_ADD;
    bus_if.operand = 16'h1000;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("mid_mul_acc",  bus_if.acc_out, 16'h0003);
    chk("mid_mul_busy", bus_if.busy, 1'b1);
    wait_done(lat, bcnt);
    chk("mul5_acc", bus_if.acc_out, 16'h000F);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("done_start_busy", bus_if.busy, 1'b0);
    @(negedge clk);
    chk("done_start_idle", bus_if.busy, 1'b0);
    chk("done_start_acc",  bus_if.acc_out, 16'h000F);

    // async reset during SHIFT
    run_op("load00ff", OP_LOAD, 16'h00FF, 1, 16'h00FF);
    issue(OP_SLL, 16'h0008);
    @(negedge clk);
    chk("shift_mid_acc",   bus_if.acc_out, 16'h01FE);
    chk("shift_mid_state", bus_if.state, ST_SHIFT);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc",   bus_if.acc_out, 16'h0000);
    chk("arst_busy",  bus_if.busy, 1'b0);
    chk("arst_done",  bus_if.done, 1'b0);
    chk("arst_state", bus_if.state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    run_op("load42", OP_LOAD, 16'h0042, 1, 16'h0042);
    run_op("sra1", OP_SRA, 16'h0001, 2, 16'h0021);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
